// File: rtl/motctl_sequencer.sv
// Timed motion-command sequencer for the Rojobot motor control input.
// Buffers {motor byte, tick count} commands and plays them back against upd_sysregs.
module motctl_sequencer #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_wr,
  input  logic [7:0]    cmd_mot,
  input  logic [7:0]    cmd_ticks,
  input  logic          start,
  input  logic          abort,
  input  logic          upd_sysregs,
  input  logic [7:0]    Sensors_reg,
  input  logic [7:0]    stop_mask,
  output logic [7:0]    MotCtl_out,
  output logic          busy,
  output logic          done,
  output logic          aborted,
  output logic          ovf,
  output logic          cmd_full,
  output logic [AW:0]   cmd_count,
  output logic [7:0]    ticks_left
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_STOP = 2'd3
  } state_t;

  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mot_mem   [DEPTH];
  logic [7:0]    ticks_mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  state_t state;
  state_t state_next;
  logic   stop_abort;
  logic   stop_abort_next;
  logic   pop;
  logic   flush;
  logic   push_ok;
  logic   dec;
  logic   sensor_hit;
  logic   expire;

  always_comb begin
    state_next      = state;
    stop_abort_next = stop_abort;
    pop             = 1'b0;
    flush           = 1'b0;
    dec             = 1'b0;
    sensor_hit      = |(Sensors_reg & stop_mask);
    // A command loaded as 0 counts 0,255,...,1, so expiry at 1 covers the 256 case.
    expire          = (ticks_left == 8'd1);
    case (state)
      S_IDLE: begin
        if (abort) begin
          flush = 1'b1;
        end else if (start && (count != '0)) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_next      = S_STOP;
          stop_abort_next = 1'b1;
        end else begin
          pop        = 1'b1;
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next      = S_STOP;
          stop_abort_next = 1'b1;
        end else if (upd_sysregs) begin
          if (sensor_hit) begin
            state_next      = S_STOP;
            stop_abort_next = 1'b1;
          end else if (expire) begin
            if (count != '0) begin
              state_next = S_LOAD;
            end else begin
              state_next      = S_STOP;
              stop_abort_next = 1'b0;
            end
          end else begin
            dec = 1'b1;
          end
        end
      end
      S_STOP: begin
        flush      = stop_abort;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // A flush discards any push landing in the same cycle without flagging overflow.
    push_ok = cmd_wr && !flush && ((count != FULL_CNT) || pop);
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mot_mem[wr_ptr]   <= cmd_mot;
      ticks_mem[wr_ptr] <= cmd_ticks;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      stop_abort <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      MotCtl_out <= 8'h00;
      ticks_left <= 8'h00;
      done       <= 1'b0;
      aborted    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      state      <= state_next;
      stop_abort <= stop_abort_next;
      done       <= (state == S_STOP) && !stop_abort;
      aborted    <= ((state == S_STOP) && stop_abort) || ((state == S_IDLE) && abort);
      ovf        <= cmd_wr && !flush && !push_ok;

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
        if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
        case ({push_ok, pop})
          2'b10:   count <= count + CNT_ONE;
          2'b01:   count <= count - CNT_ONE;
          default: count <= count;
        endcase
      end

      if (pop) begin
        MotCtl_out <= mot_mem[rd_ptr];
        ticks_left <= ticks_mem[rd_ptr];
      end else if (dec) begin
        ticks_left <= ticks_left - 8'd1;
      end else if (state == S_STOP) begin
        MotCtl_out <= 8'h00;
        ticks_left <= 8'h00;
      end
    end
  end

  assign busy      = (state != S_IDLE);
  assign cmd_full  = (count == FULL_CNT);
  assign cmd_count = count;

endmodule

// File: tb/tb_motctl_sequencer.sv
// Self-checking bench for motctl_sequencer: command table, expected-command
// queue popped as each command reaches MotCtl_out, and multi-cycle corner cases.
module tb_motctl_sequencer;

  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic          clk;
  logic          reset;
  logic          cmd_wr;
  logic [7:0]    cmd_mot;
  logic [7:0]    cmd_ticks;
  logic          start;
  logic          abort;
  logic          upd_sysregs;
  logic [7:0]    Sensors_reg;
  logic [7:0]    stop_mask;
  logic [7:0]    MotCtl_out;
  logic          busy;
  logic          done;
  logic          aborted;
  logic          ovf;
  logic          cmd_full;
  logic [AW:0]   cmd_count;
  logic [7:0]    ticks_left;

  motctl_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_wr      (cmd_wr),
    .cmd_mot     (cmd_mot),
    .cmd_ticks   (cmd_ticks),
    .start       (start),
    .abort       (abort),
    .upd_sysregs (upd_sysregs),
    .Sensors_reg (Sensors_reg),
    .stop_mask   (stop_mask),
    .MotCtl_out  (MotCtl_out),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .ovf         (ovf),
    .cmd_full    (cmd_full),
    .cmd_count   (cmd_count),
    .ticks_left  (ticks_left)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] mot;
    logic [7:0] ticks;
    int         len;
  } vec_t;

  vec_t vecs [11];

  logic [7:0] exp_q [$];
  logic [7:0] tk_q  [$];
  int         len_q [$];

  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int aborted_seen = 0;
  int ovf_seen = 0;

  always @(negedge clk) begin
    if (done)    done_seen++;
    if (aborted) aborted_seen++;
    if (ovf)     ovf_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_sb();
    exp_q.delete();
    tk_q.delete();
    len_q.delete();
  endtask

  // driver: one-cycle push; accepted pushes enter the scoreboard
  task automatic push_cmd(input logic [7:0] mot, input logic [7:0] tk, input int len, input logic accept);
    cmd_wr    = 1'b1;
    cmd_mot   = mot;
    cmd_ticks = tk;
    tick();
    cmd_wr = 1'b0;
    check("ovf_on_push", 32'(ovf), 32'(!accept));
    if (accept) begin
      exp_q.push_back(mot);
      tk_q.push_back(tk);
      len_q.push_back(len);
    end
  endtask

  // starts the queue and plays every scoreboard entry with spaced update pulses
  task automatic run_queue();
    int n;
    logic [7:0] em;
    logic [7:0] et;
    int el;
    n = exp_q.size();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_in_load", 32'(busy), 1);
    check("mot_in_load", 32'(MotCtl_out), 0);
    tick();
    for (int i = 0; i < n; i++) begin
      em = exp_q.pop_front();
      et = tk_q.pop_front();
      el = len_q.pop_front();
      check("mot_loaded", 32'(MotCtl_out), 32'(em));
      check("ticks_loaded", 32'(ticks_left), 32'(et));
      for (int p = 0; p < el; p++) begin
        upd_sysregs = 1'b1;
        tick();
        upd_sysregs = 1'b0;
        if (p == el - 1) begin
          check("mot_held_at_expiry", 32'(MotCtl_out), 32'(em));
          check("busy_at_expiry", 32'(busy), 1);
        end
        tick();
        if (p < el - 1) begin
          check("ticks_dec", 32'(ticks_left), 32'(8'(et - 8'(p + 1))));
        end
      end
    end
    check("done_pulse", 32'(done), 1);
    check("mot_after_done", 32'(MotCtl_out), 0);
    check("ticks_after_done", 32'(ticks_left), 0);
    tick();
    check("done_one_cycle", 32'(done), 0);
    check("busy_after_done", 32'(busy), 0);
    check("count_after_done", 32'(cmd_count), 0);
  endtask

  initial begin
    vecs[0]  = '{8'h33, 8'd2, 2};
    vecs[1]  = '{8'hCC, 8'd1, 1};
    vecs[2]  = '{8'h01, 8'd1, 1};
    vecs[3]  = '{8'h12, 8'd3, 3};
    vecs[4]  = '{8'h23, 8'd2, 2};
    vecs[5]  = '{8'h34, 8'd1, 1};
    vecs[6]  = '{8'h45, 8'd2, 2};
    vecs[7]  = '{8'h56, 8'd3, 3};
    vecs[8]  = '{8'h67, 8'd1, 1};
    vecs[9]  = '{8'h78, 8'd2, 2};
    vecs[10] = '{8'h11, 8'd0, 256};

    reset       = 1'b1;
    cmd_wr      = 1'b0;
    cmd_mot     = 8'h00;
    cmd_ticks   = 8'h00;
    start       = 1'b0;
    abort       = 1'b0;
    upd_sysregs = 1'b0;
    Sensors_reg = 8'h00;
    stop_mask   = 8'h00;
    tick();
    tick();
    check("rst_mot", 32'(MotCtl_out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_aborted", 32'(aborted), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_full", 32'(cmd_full), 0);
    check("rst_count", 32'(cmd_count), 0);
    check("rst_ticks", 32'(ticks_left), 0);
    reset = 1'b0;
    tick();

    // start on an empty FIFO is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    check("empty_start_busy", 32'(busy), 0);
    tick();
    check("empty_start_busy2", 32'(busy), 0);

    // basic sequence
    for (int i = 0; i < 2; i++) push_cmd(vecs[i].mot, vecs[i].ticks, vecs[i].len, 1'b1);
    check("basic_count", 32'(cmd_count), 2);
    run_queue();

    // overflow then run through the wrapped pointers
    for (int i = 2; i < 10; i++) push_cmd(vecs[i].mot, vecs[i].ticks, vecs[i].len, 1'b1);
    check("ovf_full", 32'(cmd_full), 1);
    check("ovf_count", 32'(cmd_count), 8);
    push_cmd(8'hEE, 8'd1, 1, 1'b0);
    check("ovf_count_kept", 32'(cmd_count), 8);
    run_queue();
    for (int i = 9; i >= 2; i--) push_cmd(vecs[i].mot, vecs[i].ticks, vecs[i].len, 1'b1);
    check("wrap_full", 32'(cmd_full), 1);
    run_queue();

    // zero ticks means 256 pulses
    push_cmd(vecs[10].mot, vecs[10].ticks, vecs[10].len, 1'b1);
    run_queue();

    // sensor stop before the second pulse
    stop_mask = 8'h01;
    for (int i = 0; i < 3; i++) push_cmd(8'h33, 8'd5, 5, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("sens_mot", 32'(MotCtl_out), 32'(exp_q.pop_front()));
    upd_sysregs = 1'b1;
    tick();
    upd_sysregs = 1'b0;
    tick();
    check("sens_ticks_dec", 32'(ticks_left), 4);
    Sensors_reg = 8'h01;
    upd_sysregs = 1'b1;
    tick();
    upd_sysregs = 1'b0;
    check("sens_stop_busy", 32'(busy), 1);
    check("sens_stop_mot_held", 32'(MotCtl_out), 8'h33);
    check("sens_stop_ticks_held", 32'(ticks_left), 4);
    tick();
    clear_sb();
    check("sens_aborted", 32'(aborted), 1);
    check("sens_done", 32'(done), 0);
    check("sens_mot0", 32'(MotCtl_out), 0);
    check("sens_count0", 32'(cmd_count), 0);
    check("sens_ticks0", 32'(ticks_left), 0);
    Sensors_reg = 8'h00;
    tick();
    check("sens_aborted_clear", 32'(aborted), 0);
    check("sens_idle", 32'(busy), 0);

    // full FIFO push in the LOAD pop cycle, then abort on the expiry pulse
    for (int i = 0; i < DEPTH; i++) push_cmd(8'h60 + 8'(i), 8'd1, 1, 1'b1);
    check("sim_full", 32'(cmd_full), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    cmd_wr    = 1'b1;
    cmd_mot   = 8'h77;
    cmd_ticks = 8'd1;
    tick();
    cmd_wr = 1'b0;
    exp_q.push_back(8'h77);
    check("sim_push_ovf", 32'(ovf), 0);
    check("sim_push_count", 32'(cmd_count), 8);
    check("sim_push_full", 32'(cmd_full), 1);
    check("sim_mot", 32'(MotCtl_out), 32'(exp_q.pop_front()));
    upd_sysregs = 1'b1;
    abort       = 1'b1;
    tick();
    upd_sysregs = 1'b0;
    abort       = 1'b0;
    check("sim_stop_busy", 32'(busy), 1);
    tick();
    clear_sb();
    check("sim_aborted", 32'(aborted), 1);
    check("sim_done", 32'(done), 0);
    check("sim_mot0", 32'(MotCtl_out), 0);
    check("sim_count0", 32'(cmd_count), 0);
    check("sim_full0", 32'(cmd_full), 0);
    tick();

    // abort while idle flushes the queue
    push_cmd(8'h21, 8'd2, 2, 1'b1);
    push_cmd(8'h22, 8'd2, 2, 1'b1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    clear_sb();
    check("idle_abort_pulse", 32'(aborted), 1);
    check("idle_abort_count", 32'(cmd_count), 0);
    check("idle_abort_busy", 32'(busy), 0);
    tick();
    check("idle_abort_clear", 32'(aborted), 0);

    // reset in the middle of RUN
    push_cmd(8'h44, 8'd3, 3, 1'b1);
    push_cmd(8'h55, 8'd2, 2, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("rr_mot", 32'(MotCtl_out), 32'(exp_q.pop_front()));
    upd_sysregs = 1'b1;
    tick();
    upd_sysregs = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_sb();
    check("rr_mot0", 32'(MotCtl_out), 0);
    check("rr_busy", 32'(busy), 0);
    check("rr_count", 32'(cmd_count), 0);
    check("rr_ticks", 32'(ticks_left), 0);
    check("rr_done", 32'(done), 0);
    check("rr_aborted", 32'(aborted), 0);
    tick();
    tick();
    check("rr_done_after", 32'(done), 0);
    check("rr_aborted_after", 32'(aborted), 0);

    check("total_done_pulses", 32'(done_seen), 4);
    check("total_aborted_pulses", 32'(aborted_seen), 3);
    check("total_ovf_pulses", 32'(ovf_seen), 1);
    check("scoreboard_empty", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
